// File: rtl/axi_stream_chan_pkg.sv
// rtl/axi_stream_chan_pkg.sv - channel tags, payload widths and layouts shared by both ends of the AXI-to-stream bridge
package axi_stream_chan_pkg;

    typedef enum logic [2:0] {
        CH_AR = 3'd0,
        CH_AW = 3'd1,
        CH_R  = 3'd2,
        CH_W  = 3'd3,
        CH_B  = 3'd4
    } chan_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int ID_W_DEF   = 4;
    localparam int AXLEN_W    = 8;
    localparam int AXSIZE_W   = 3;
    localparam int AXBURST_W  = 2;
    localparam int RESP_W     = 2;

    function automatic int ax_width(input int id_w, input int addr_w);
        return id_w + addr_w + AXLEN_W + AXSIZE_W + AXBURST_W;
    endfunction

    function automatic int w_width(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

    function automatic int r_width(input int id_w, input int data_w);
        return id_w + data_w + RESP_W + 1;
    endfunction

    function automatic int b_width(input int id_w);
        return id_w + RESP_W;
    endfunction

    function automatic int max_payload(input int id_w, input int addr_w, input int data_w);
        int m;
        m = ax_width(id_w, addr_w);
        if (w_width(data_w) > m)       m = w_width(data_w);
        if (r_width(id_w, data_w) > m) m = r_width(id_w, data_w);
        if (b_width(id_w) > m)         m = b_width(id_w);
        return m;
    endfunction

    // Packed layouts at the default widths; the first field listed is the MSB.
    typedef struct packed {
        logic [AXBURST_W-1:0]  burst;
        logic [AXSIZE_W-1:0]   size;
        logic [AXLEN_W-1:0]    len;
        logic [ADDR_W_DEF-1:0] addr;
        logic [ID_W_DEF-1:0]   id;
    } ar_t;

    typedef struct packed {
        logic                    last;
        logic [DATA_W_DEF/8-1:0] strb;
        logic [DATA_W_DEF-1:0]   data;
    } w_t;

    typedef struct packed {
        logic                  last;
        logic [RESP_W-1:0]     resp;
        logic [DATA_W_DEF-1:0] data;
        logic [ID_W_DEF-1:0]   id;
    } r_t;

    typedef struct packed {
        logic [RESP_W-1:0]   resp;
        logic [ID_W_DEF-1:0] id;
    } b_t;

endpackage

// File: rtl/stream_to_axi_demux_if.sv
// rtl/stream_to_axi_demux_if.sv - tagged input stream plus the five rebuilt AXI4 channels
interface stream_to_axi_demux_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TDATA_W = 64
);
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [TDATA_W-1:0] s_axis_tdata;
    logic [2:0]         s_axis_tdest;

    logic              m_ar_valid, m_ar_ready;
    logic [ID_W-1:0]   m_ar_id;
    logic [ADDR_W-1:0] m_ar_addr;
    logic [7:0]        m_ar_len;
    logic [2:0]        m_ar_size;
    logic [1:0]        m_ar_burst;

    logic              m_aw_valid, m_aw_ready;
    logic [ID_W-1:0]   m_aw_id;
    logic [ADDR_W-1:0] m_aw_addr;
    logic [7:0]        m_aw_len;
    logic [2:0]        m_aw_size;
    logic [1:0]        m_aw_burst;

    logic                m_w_valid, m_w_ready;
    logic [DATA_W-1:0]   m_w_data;
    logic [DATA_W/8-1:0] m_w_strb;
    logic                m_w_last;

    logic              m_r_valid, m_r_ready;
    logic [ID_W-1:0]   m_r_id;
    logic [DATA_W-1:0] m_r_data;
    logic [1:0]        m_r_resp;
    logic              m_r_last;

    logic            m_b_valid, m_b_ready;
    logic [ID_W-1:0] m_b_id;
    logic [1:0]      m_b_resp;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tdest,
        output s_axis_tready,
        input  m_ar_ready, m_aw_ready, m_w_ready, m_r_ready, m_b_ready,
        output m_ar_valid, m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst,
        output m_aw_valid, m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst,
        output m_w_valid, m_w_data, m_w_strb, m_w_last,
        output m_r_valid, m_r_id, m_r_data, m_r_resp, m_r_last,
        output m_b_valid, m_b_id, m_b_resp
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tdest,
        input  s_axis_tready,
        output m_ar_ready, m_aw_ready, m_w_ready, m_r_ready, m_b_ready,
        input  m_ar_valid, m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst,
        input  m_aw_valid, m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst,
        input  m_w_valid, m_w_data, m_w_strb, m_w_last,
        input  m_r_valid, m_r_id, m_r_data, m_r_resp, m_r_last,
        input  m_b_valid, m_b_id, m_b_resp
    );
endinterface

// File: rtl/axis_chan_skid.sv
// rtl/axis_chan_skid.sv - 2-entry per-channel FIFO with occupancy output and synchronous flush
module axis_chan_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign do_push = push_i && (count_q != 2'd2);
    assign do_pop  = pop_i && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + 2'd1;
        else if (!do_push && do_pop) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/stream_to_axi_demux.sv
// rtl/stream_to_axi_demux.sv - splits a TDEST-tagged stream back into independent AR/AW/R/W/B channels
module stream_to_axi_demux
    import axi_stream_chan_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TDATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  RESETN_AR,
    input  logic                  RESETN_AW,
    input  logic                  RESETN_R,
    input  logic                  RESETN_W,
    input  logic                  RESETN_B,
    stream_to_axi_demux_if.slave  bus,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           bad_dest_cnt
);
    localparam int AX_W  = ax_width(ID_W, ADDR_W);
    localparam int W_W   = w_width(DATA_W);
    localparam int R_W   = r_width(ID_W, DATA_W);
    localparam int B_W   = b_width(ID_W);
    localparam int MAX_W = max_payload(ID_W, ADDR_W, DATA_W);

    if (TDATA_W < MAX_W) begin : g_tdata_chk
        $error("stream_to_axi_demux: TDATA_W narrower than largest channel payload");
    end else if (TDATA_W > MAX_W) begin : g_tdata_hi
        logic unused_tdata_hi;
        assign unused_tdata_hi = ^bus.s_axis_tdata[TDATA_W-1:MAX_W];
    end

    logic        run_q;
    logic [15:0] drop_cnt_q, drop_cnt_d, bad_cnt_q, bad_cnt_d;
    logic [2:0]  dest;
    logic        dest_ok, accept;
    logic [7:0]  en;
    logic [1:0]  cnt [8];

    logic [1:0]      cnt_ar, cnt_aw, cnt_r, cnt_w, cnt_b;
    logic [AX_W-1:0] ar_q, aw_q;
    logic [W_W-1:0]  w_q;
    logic [R_W-1:0]  r_q;
    logic [B_W-1:0]  b_q;

    assign dest    = bus.s_axis_tdest;
    assign dest_ok = (dest <= 3'd4);
    assign en      = {3'b000, RESETN_B, RESETN_W, RESETN_R, RESETN_AW, RESETN_AR};

    always_comb begin
        for (int i = 0; i < 8; i++) cnt[i] = 2'd0;
        cnt[CH_AR] = cnt_ar;
        cnt[CH_AW] = cnt_aw;
        cnt[CH_R]  = cnt_r;
        cnt[CH_W]  = cnt_w;
        cnt[CH_B]  = cnt_b;
    end

    // Ready looks only at the head beat's own channel, so one stalled channel never blocks the others.
    assign bus.s_axis_tready = run_q && (!dest_ok || !en[dest] || (cnt[dest] != 2'd2));
    assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (accept && dest_ok && !en[dest] && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
        if (accept && !dest_ok && (bad_cnt_q != 16'hFFFF))
            bad_cnt_d = bad_cnt_q + 16'd1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            run_q      <= 1'b0;
            drop_cnt_q <= 16'd0;
            bad_cnt_q  <= 16'd0;
        end else begin
            run_q      <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign drop_cnt     = drop_cnt_q;
    assign bad_dest_cnt = bad_cnt_q;

    axis_chan_skid #(.W(AX_W)) u_ar (
        .clk(aclk), .resetn(aresetn), .flush_i(!RESETN_AR),
        .push_i(accept && dest == CH_AR && RESETN_AR), .data_i(bus.s_axis_tdata[AX_W-1:0]),
        .pop_i(bus.m_ar_ready), .valid_o(bus.m_ar_valid), .data_o(ar_q), .count_o(cnt_ar)
    );

    axis_chan_skid #(.W(AX_W)) u_aw (
        .clk(aclk), .resetn(aresetn), .flush_i(!RESETN_AW),
        .push_i(accept && dest == CH_AW && RESETN_AW), .data_i(bus.s_axis_tdata[AX_W-1:0]),
        .pop_i(bus.m_aw_ready), .valid_o(bus.m_aw_valid), .data_o(aw_q), .count_o(cnt_aw)
    );

    axis_chan_skid #(.W(R_W)) u_r (
        .clk(aclk), .resetn(aresetn), .flush_i(!RESETN_R),
        .push_i(accept && dest == CH_R && RESETN_R), .data_i(bus.s_axis_tdata[R_W-1:0]),
        .pop_i(bus.m_r_ready), .valid_o(bus.m_r_valid), .data_o(r_q), .count_o(cnt_r)
    );

    axis_chan_skid #(.W(W_W)) u_w (
        .clk(aclk), .resetn(aresetn), .flush_i(!RESETN_W),
        .push_i(accept && dest == CH_W && RESETN_W), .data_i(bus.s_axis_tdata[W_W-1:0]),
        .pop_i(bus.m_w_ready), .valid_o(bus.m_w_valid), .data_o(w_q), .count_o(cnt_w)
    );

    axis_chan_skid #(.W(B_W)) u_b (
        .clk(aclk), .resetn(aresetn), .flush_i(!RESETN_B),
        .push_i(accept && dest == CH_B && RESETN_B), .data_i(bus.s_axis_tdata[B_W-1:0]),
        .pop_i(bus.m_b_ready), .valid_o(bus.m_b_valid), .data_o(b_q), .count_o(cnt_b)
    );

    // Fields are packed LSB first: the ID (or data for W) sits at bit 0.
    assign bus.m_ar_id    = ar_q[ID_W-1:0];
    assign bus.m_ar_addr  = ar_q[ID_W +: ADDR_W];
    assign bus.m_ar_len   = ar_q[ID_W+ADDR_W +: 8];
    assign bus.m_ar_size  = ar_q[ID_W+ADDR_W+8 +: 3];
    assign bus.m_ar_burst = ar_q[ID_W+ADDR_W+11 +: 2];

    assign bus.m_aw_id    = aw_q[ID_W-1:0];
    assign bus.m_aw_addr  = aw_q[ID_W +: ADDR_W];
    assign bus.m_aw_len   = aw_q[ID_W+ADDR_W +: 8];
    assign bus.m_aw_size  = aw_q[ID_W+ADDR_W+8 +: 3];
    assign bus.m_aw_burst = aw_q[ID_W+ADDR_W+11 +: 2];

    assign bus.m_w_data = w_q[DATA_W-1:0];
    assign bus.m_w_strb = w_q[DATA_W +: DATA_W/8];
    assign bus.m_w_last = w_q[DATA_W+DATA_W/8];

    assign bus.m_r_id   = r_q[ID_W-1:0];
    assign bus.m_r_data = r_q[ID_W +: DATA_W];
    assign bus.m_r_resp = r_q[ID_W+DATA_W +: 2];
    assign bus.m_r_last = r_q[ID_W+DATA_W+2];

    assign bus.m_b_id   = b_q[ID_W-1:0];
    assign bus.m_b_resp = b_q[ID_W +: 2];
endmodule

// File: tb/tb_stream_to_axi_demux.sv
// tb/tb_stream_to_axi_demux.sv - directed self-checking bench for stream_to_axi_demux
module tb_stream_to_axi_demux;
    logic aclk = 1'b0;
    logic aresetn, en_ar, en_aw, en_r, en_w, en_b;
    logic [15:0] drop_cnt, bad_dest_cnt;
    int checks = 0;
    int errors = 0;
    bit ok;

    stream_to_axi_demux_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .TDATA_W(64)) bus ();

    stream_to_axi_demux #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .TDATA_W(64)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .RESETN_AR(en_ar), .RESETN_AW(en_aw), .RESETN_R(en_r), .RESETN_W(en_w), .RESETN_B(en_b),
        .bus(bus), .drop_cnt(drop_cnt), .bad_dest_cnt(bad_dest_cnt)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Offers one beat and holds it until accepted (bounded); ok reports acceptance.
    task automatic send_beat(input logic [2:0] dest, input logic [63:0] data, output bit acc);
        bus.s_axis_tdest  = dest;
        bus.s_axis_tdata  = data;
        bus.s_axis_tvalid = 1'b1;
        #1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.s_axis_tready === 1'b1) begin
                acc = 1'b1;
                break;
            end
            step();
        end
        if (acc) step();
        bus.s_axis_tvalid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        en_ar = 1'b1; en_aw = 1'b1; en_r = 1'b1; en_w = 1'b1; en_b = 1'b1;
        bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tdest = 3'd0;
        bus.m_ar_ready = 1'b0; bus.m_aw_ready = 1'b0; bus.m_w_ready = 1'b0;
        bus.m_r_ready = 1'b0; bus.m_b_ready = 1'b0;
        step(); step();
        checks++;
        if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", bus.s_axis_tready); end
        checks++;
        if ({bus.m_ar_valid, bus.m_aw_valid, bus.m_r_valid, bus.m_w_valid, bus.m_b_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b want 00000",
                     {bus.m_ar_valid, bus.m_aw_valid, bus.m_r_valid, bus.m_w_valid, bus.m_b_valid});
        end
        checks++;
        if (drop_cnt !== 16'd0 || bad_dest_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counters: got drop=%0d bad=%0d want 0 0", drop_cnt, bad_dest_cnt);
        end
        aresetn = 1'b1;
        step();
        checks++;
        if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready: got %b want 1", bus.s_axis_tready); end
    endtask

    task automatic test_ar_beat();
        send_beat(3'd0, {15'b0, 2'd1, 3'd2, 8'd7, 32'h1000_0040, 4'd3}, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ar_accept: beat not accepted"); end
        checks++;
        if (bus.m_ar_valid !== 1'b1) begin errors++; $display("FAIL ar_valid: got %b want 1", bus.m_ar_valid); end
        checks++;
        if ({bus.m_ar_id, bus.m_ar_addr, bus.m_ar_len, bus.m_ar_size, bus.m_ar_burst}
                !== {4'd3, 32'h1000_0040, 8'd7, 3'd2, 2'd1}) begin
            errors++;
            $display("FAIL ar_fields: got id=%0d addr=%h len=%0d size=%0d burst=%0d want 3 10000040 7 2 1",
                     bus.m_ar_id, bus.m_ar_addr, bus.m_ar_len, bus.m_ar_size, bus.m_ar_burst);
        end
        checks++;
        if (bus.m_aw_valid !== 1'b0) begin errors++; $display("FAIL ar_no_aw: got %b want 0", bus.m_aw_valid); end
        bus.m_ar_ready = 1'b1;
        step();
        bus.m_ar_ready = 1'b0;
        checks++;
        if (bus.m_ar_valid !== 1'b0) begin errors++; $display("FAIL ar_drain: got %b want 0", bus.m_ar_valid); end
    endtask

    task automatic test_w_backpressure();
        send_beat(3'd3, {27'b0, 1'b0, 4'hF, 32'h0000_00A1}, ok);
        send_beat(3'd3, {27'b0, 1'b0, 4'h3, 32'h0000_00B2}, ok);
        bus.s_axis_tdest = 3'd3;
        bus.s_axis_tdata = {27'b0, 1'b1, 4'hC, 32'h0000_00C3};
        bus.s_axis_tvalid = 1'b1;
        #1;
        checks++;
        if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL w_full_tready: got %b want 0", bus.s_axis_tready); end
        step();
        checks++;
        if (bus.s_axis_tready !== 1'b0 || bus.m_w_data !== 32'hA1 || bus.m_w_strb !== 4'hF) begin
            errors++;
            $display("FAIL w_head_held: got tready=%b data=%h strb=%h want 0 a1 f",
                     bus.s_axis_tready, bus.m_w_data, bus.m_w_strb);
        end
        bus.m_w_ready = 1'b1;
        step();
        checks++;
        if (bus.m_w_valid !== 1'b1 || bus.m_w_data !== 32'hB2 || bus.m_w_strb !== 4'h3) begin
            errors++;
            $display("FAIL w_second: got valid=%b data=%h strb=%h want 1 b2 3", bus.m_w_valid, bus.m_w_data, bus.m_w_strb);
        end
        checks++;
        if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL w_ready_again: got %b want 1", bus.s_axis_tready); end
        step();
        bus.s_axis_tvalid = 1'b0;
        checks++;
        if (bus.m_w_valid !== 1'b1 || bus.m_w_data !== 32'hC3 || bus.m_w_last !== 1'b1) begin
            errors++;
            $display("FAIL w_third: got valid=%b data=%h last=%b want 1 c3 1", bus.m_w_valid, bus.m_w_data, bus.m_w_last);
        end
        step();
        bus.m_w_ready = 1'b0;
        checks++;
        if (bus.m_w_valid !== 1'b0) begin errors++; $display("FAIL w_empty: got %b want 0", bus.m_w_valid); end
    endtask

    task automatic test_drop();
        en_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_beat(3'd4, {58'b0, 2'd1, 4'(i)}, ok);
            checks++;
            if (!ok || bus.m_b_valid !== 1'b0) begin
                errors++; $display("FAIL drop_beat%0d: got accepted=%b b_valid=%b want 1 0", i, ok, bus.m_b_valid);
            end
        end
        checks++;
        if (drop_cnt !== 16'd4) begin errors++; $display("FAIL drop_cnt: got %0d want 4", drop_cnt); end
        en_b = 1'b1;
        step();
        checks++;
        if (bus.m_b_valid !== 1'b0) begin errors++; $display("FAIL drop_reenable: got %b want 0", bus.m_b_valid); end
        send_beat(3'd4, {58'b0, 2'd2, 4'd9}, ok);
        checks++;
        if (bus.m_b_valid !== 1'b1 || bus.m_b_id !== 4'd9 || bus.m_b_resp !== 2'd2) begin
            errors++;
            $display("FAIL b_after_drop: got valid=%b id=%0d resp=%0d want 1 9 2", bus.m_b_valid, bus.m_b_id, bus.m_b_resp);
        end
        bus.m_b_ready = 1'b1;
        step();
        bus.m_b_ready = 1'b0;
    endtask

    task automatic test_bad_dest();
        send_beat(3'd6, 64'hDEAD_BEEF_0000_1234, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bad_accept: beat not accepted"); end
        checks++;
        if ({bus.m_ar_valid, bus.m_aw_valid, bus.m_r_valid, bus.m_w_valid, bus.m_b_valid} !== 5'b0) begin
            errors++;
            $display("FAIL bad_valids: got %b want 00000",
                     {bus.m_ar_valid, bus.m_aw_valid, bus.m_r_valid, bus.m_w_valid, bus.m_b_valid});
        end
        checks++;
        if (bad_dest_cnt !== 16'd1 || drop_cnt !== 16'd4) begin
            errors++; $display("FAIL bad_counters: got bad=%0d drop=%0d want 1 4", bad_dest_cnt, drop_cnt);
        end
    endtask

    task automatic test_stall_other();
        send_beat(3'd2, {25'b0, 1'b0, 2'd0, 32'h0000_0011, 4'd1}, ok);
        send_beat(3'd2, {25'b0, 1'b0, 2'd1, 32'h0000_0022, 4'd2}, ok);
        bus.s_axis_tdest = 3'd2;
        bus.s_axis_tdata = {25'b0, 1'b1, 2'd0, 32'h0000_0033, 4'd3};
        bus.s_axis_tvalid = 1'b1;
        step();
        checks++;
        if (bus.s_axis_tready !== 1'b0 || bus.m_aw_valid !== 1'b0) begin
            errors++; $display("FAIL r_head_block: got tready=%b aw_valid=%b want 0 0", bus.s_axis_tready, bus.m_aw_valid);
        end
        bus.m_r_ready = 1'b1;
        step();
        checks++;
        if (bus.s_axis_tready !== 1'b1 || bus.m_r_data !== 32'h22 || bus.m_r_id !== 4'd2 || bus.m_r_resp !== 2'd1) begin
            errors++;
            $display("FAIL r_second: got tready=%b data=%h id=%0d resp=%0d want 1 22 2 1",
                     bus.s_axis_tready, bus.m_r_data, bus.m_r_id, bus.m_r_resp);
        end
        step();
        bus.s_axis_tvalid = 1'b0;
        bus.m_r_ready = 1'b0;
        checks++;
        if (bus.m_r_valid !== 1'b1 || bus.m_r_data !== 32'h33 || bus.m_r_last !== 1'b1) begin
            errors++;
            $display("FAIL r_third: got valid=%b data=%h last=%b want 1 33 1", bus.m_r_valid, bus.m_r_data, bus.m_r_last);
        end
        send_beat(3'd1, {15'b0, 2'd1, 3'd2, 8'd3, 32'h2000_0100, 4'd5}, ok);
        checks++;
        if (!ok || bus.m_aw_valid !== 1'b1 || bus.m_aw_addr !== 32'h2000_0100 || bus.m_aw_id !== 4'd5
                || bus.m_aw_len !== 8'd3) begin
            errors++;
            $display("FAIL aw_after_r: got acc=%b valid=%b addr=%h id=%0d len=%0d want 1 1 20000100 5 3",
                     ok, bus.m_aw_valid, bus.m_aw_addr, bus.m_aw_id, bus.m_aw_len);
        end
        en_r = 1'b0;
        step();
        en_r = 1'b1;
        checks++;
        if (bus.m_r_valid !== 1'b0) begin errors++; $display("FAIL r_flush: got %b want 0", bus.m_r_valid); end
        checks++;
        if (bus.m_aw_valid !== 1'b1 || bus.m_aw_addr !== 32'h2000_0100) begin
            errors++; $display("FAIL aw_kept: got valid=%b addr=%h want 1 20000100", bus.m_aw_valid, bus.m_aw_addr);
        end
        bus.m_aw_ready = 1'b1;
        step();
        bus.m_aw_ready = 1'b0;
        checks++;
        if (bus.m_aw_valid !== 1'b0) begin errors++; $display("FAIL aw_drain: got %b want 0", bus.m_aw_valid); end
    endtask

    task automatic test_flush_w();
        send_beat(3'd3, {27'b0, 1'b0, 4'h1, 32'h0000_0D01}, ok);
        send_beat(3'd3, {27'b0, 1'b0, 4'h2, 32'h0000_0D02}, ok);
        checks++;
        if (bus.m_w_valid !== 1'b1 || bus.m_w_data !== 32'hD01) begin
            errors++; $display("FAIL w_queued: got valid=%b data=%h want 1 d01", bus.m_w_valid, bus.m_w_data);
        end
        en_w = 1'b0;
        step();
        en_w = 1'b1;
        checks++;
        if (bus.m_w_valid !== 1'b0) begin errors++; $display("FAIL w_flush: got %b want 0", bus.m_w_valid); end
        send_beat(3'd3, {27'b0, 1'b1, 4'h8, 32'h0000_0E05}, ok);
        checks++;
        if (!ok || bus.m_w_valid !== 1'b1 || bus.m_w_data !== 32'hE05 || bus.m_w_strb !== 4'h8 || bus.m_w_last !== 1'b1) begin
            errors++;
            $display("FAIL w_after_flush: got acc=%b valid=%b data=%h strb=%h last=%b want 1 1 e05 8 1",
                     ok, bus.m_w_valid, bus.m_w_data, bus.m_w_strb, bus.m_w_last);
        end
        checks++;
        if (drop_cnt !== 16'd4) begin errors++; $display("FAIL drop_unchanged: got %0d want 4", drop_cnt); end
        bus.m_w_ready = 1'b1;
        step();
        bus.m_w_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ar_beat();
        test_w_backpressure();
        test_drop();
        test_bad_dest();
        test_stall_other();
        test_flush_w();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
